// File: rtl/indicator_pkg.sv
// Shared types and bit-ordering helpers for the front-panel indicator driver.
package indicator_pkg;

  // Transfer sequencer states.
  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    SHIFT_LO = 2'd1,
    SHIFT_HI = 2'd2,
    LATCH    = 2'd3
  } state_t;

  // Bit ordering selectors.
  localparam int LAYOUT_LINEAR = 32'sd0;
  localparam int LAYOUT_PANEL  = 32'sd1;

  // Slot (0 = first sent) of a lamp inside one 16-bit panel group.
  // The group covers rows 0..3 and four adjacent columns (lane 0..3).
  function automatic logic [3:0] panel_slot(input int row, input int lane);
    logic [3:0] key;
    logic [3:0] slot;
    key = 4'((row * 32'sd4) + lane);
    case (key)
      4'd0:    slot = 4'd14;  // r0c0
      4'd1:    slot = 4'd12;  // r0c1
      4'd2:    slot = 4'd11;  // r0c2
      4'd3:    slot = 4'd9;   // r0c3
      4'd4:    slot = 4'd15;  // r1c0
      4'd5:    slot = 4'd13;  // r1c1
      4'd6:    slot = 4'd10;  // r1c2
      4'd7:    slot = 4'd8;   // r1c3
      4'd8:    slot = 4'd0;   // r2c0
      4'd9:    slot = 4'd2;   // r2c1
      4'd10:   slot = 4'd5;   // r2c2
      4'd11:   slot = 4'd7;   // r2c3
      4'd12:   slot = 4'd1;   // r3c0
      4'd13:   slot = 4'd3;   // r3c1
      4'd14:   slot = 4'd4;   // r3c2
      4'd15:   slot = 4'd6;   // r3c3
      default: slot = 4'd0;
    endcase
    return slot;
  endfunction

  // Serial position (0 = first bit on the wire) of lamp (row, col).
  function automatic int serial_pos(input int row, input int col,
                                    input int rows, input int cols,
                                    input int layout);
    int pos;
    if (layout == LAYOUT_PANEL) begin
      pos = ((col / 32'sd4) * 32'sd16) + int'(panel_slot(row, col % 32'sd4));
    end else begin
      // Linear: the highest-numbered lamp goes out first.
      pos = (rows * cols) - 32'sd1 - ((row * cols) + col);
    end
    return pos;
  endfunction

endpackage

// File: rtl/indicator_map.sv
// Combinational permutation of the lamp array into shift-register order.
// Bit N-1 of q is the first bit shifted out.
module indicator_map
  import indicator_pkg::*;
#(
  parameter int ROWS   = 4,
  parameter int COLS   = 36,
  parameter int LAYOUT = 1
) (
  input  logic [ROWS*COLS-1:0] d,
  output logic [ROWS*COLS-1:0] q
);

  localparam int N = ROWS * COLS;

  // Reject layouts the panel wiring cannot represent.
  if ((LAYOUT != LAYOUT_LINEAR) && (LAYOUT != LAYOUT_PANEL)) begin : g_bad_layout
    $error("indicator_map: LAYOUT must be 0 (linear) or 1 (panel)");
  end
  if ((LAYOUT == LAYOUT_PANEL) && ((ROWS != 32'sd4) || ((COLS % 32'sd4) != 32'sd0))) begin : g_bad_shape
    $error("indicator_map: panel layout needs ROWS=4 and COLS divisible by 4");
  end

  // Each lamp lands in exactly one register bit, at its wire position.
  for (genvar r = 0; r < ROWS; r++) begin : g_row
    for (genvar c = 0; c < COLS; c++) begin : g_col
      localparam int POS = serial_pos(r, c, ROWS, COLS, LAYOUT);
      assign q[N-1-POS] = d[r*COLS+c];
    end
  end

endmodule

// File: rtl/indicator_driver.sv
// Front-panel LED driver chain shifter: snapshots the lamp array, clocks it
// out serially with a self-generated sclk, then pulses the latch strobe.
module indicator_driver
  import indicator_pkg::*;
#(
  parameter int ROWS    = 4,
  parameter int COLS    = 36,
  parameter int DIV     = 50,
  parameter int REFRESH = 0,
  parameter int LAYOUT  = 1
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [ROWS*COLS-1:0] d,
  input  logic                 start,
  input  logic                 lamp_test,
  output logic                 busy,
  output logic                 done,
  output logic                 sclk,
  output logic                 sdata,
  output logic                 slatch
);

  localparam int N  = ROWS * COLS;
  localparam int DW = (DIV > 32'sd1) ? $clog2(DIV) : 32'sd1;
  localparam int BW = $clog2(N + 32'sd1);
  localparam int RW = (REFRESH > 32'sd1) ? $clog2(REFRESH) : 32'sd1;

  localparam logic [DW-1:0] DIV_LAST = DW'(DIV - 32'sd1);
  localparam logic [BW-1:0] BIT_LAST = BW'(N - 32'sd1);
  localparam logic [RW-1:0] REF_LAST = (REFRESH > 32'sd0) ? RW'(REFRESH - 32'sd1) : {RW{1'b0}};

  if (DIV < 32'sd1) begin : g_bad_div
    $error("indicator_driver: DIV must be at least 1");
  end

  state_t          state_r;
  logic [N-1:0]    shreg_r;
  logic [DW-1:0]   div_cnt_r;
  logic [BW-1:0]   bit_cnt_r;
  logic [RW-1:0]   ref_cnt_r;
  logic            pending_r;

  logic [N-1:0]    mapped_s;
  logic [N-1:0]    snap_s;
  logic            ref_hit_s;
  logic            trigger_s;

  indicator_map #(
    .ROWS   (ROWS),
    .COLS   (COLS),
    .LAYOUT (LAYOUT)
  ) u_map (
    .d (d),
    .q (mapped_s)
  );

  // The wire always carries the register MSB; it only moves on shift edges.
  assign sdata = shreg_r[N-1];

  // Snapshot source selection and refresh trigger decode.
  always_comb begin
    snap_s    = mapped_s;
    ref_hit_s = 1'b0;
    if (lamp_test) begin
      snap_s = {N{1'b1}};
    end else begin
      snap_s = mapped_s;
    end
    if (REFRESH != 32'sd0) begin
      ref_hit_s = (ref_cnt_r == REF_LAST);
    end else begin
      ref_hit_s = 1'b0;
    end
    trigger_s = start | pending_r | ref_hit_s;
  end

  // Transfer sequencer with registered serial outputs and status.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r   <= IDLE;
      shreg_r   <= {N{1'b0}};
      div_cnt_r <= {DW{1'b0}};
      bit_cnt_r <= {BW{1'b0}};
      ref_cnt_r <= {RW{1'b0}};
      pending_r <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      sclk      <= 1'b0;
      slatch    <= 1'b0;
    end else begin
      done <= 1'b0;
      // A request during a transfer is remembered once and served at the end.
      if ((state_r != IDLE) && start) begin
        pending_r <= 1'b1;
      end
      case (state_r)
        IDLE: begin
          if (trigger_s) begin
            shreg_r   <= snap_s;
            pending_r <= 1'b0;
            ref_cnt_r <= {RW{1'b0}};
            div_cnt_r <= {DW{1'b0}};
            bit_cnt_r <= {BW{1'b0}};
            busy      <= 1'b1;
            sclk      <= 1'b0;
            slatch    <= 1'b0;
            state_r   <= SHIFT_LO;
          end else if (REFRESH != 32'sd0) begin
            ref_cnt_r <= ref_cnt_r + 1'b1;
          end else begin
            ref_cnt_r <= {RW{1'b0}};
          end
        end

        SHIFT_LO: begin
          if (div_cnt_r == DIV_LAST) begin
            div_cnt_r <= {DW{1'b0}};
            sclk      <= 1'b1;
            state_r   <= SHIFT_HI;
          end else begin
            div_cnt_r <= div_cnt_r + 1'b1;
          end
        end

        SHIFT_HI: begin
          if (div_cnt_r == DIV_LAST) begin
            // Falling sclk and the next data bit change on the same edge.
            div_cnt_r <= {DW{1'b0}};
            shreg_r   <= shreg_r << 1'b1;
            bit_cnt_r <= bit_cnt_r + 1'b1;
            sclk      <= 1'b0;
            if (bit_cnt_r == BIT_LAST) begin
              slatch  <= 1'b1;
              state_r <= LATCH;
            end else begin
              state_r <= SHIFT_LO;
            end
          end else begin
            div_cnt_r <= div_cnt_r + 1'b1;
          end
        end

        LATCH: begin
          if (div_cnt_r == DIV_LAST) begin
            div_cnt_r <= {DW{1'b0}};
            slatch    <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b1;
            state_r   <= IDLE;
          end else begin
            div_cnt_r <= div_cnt_r + 1'b1;
          end
        end

        default: begin
          state_r   <= IDLE;
          div_cnt_r <= {DW{1'b0}};
          busy      <= 1'b0;
          sclk      <= 1'b0;
          slatch    <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_indicator_driver.sv
// Directed bench for indicator_driver: three instances cover the linear
// 1x8 chain, the 4x4 panel ordering and periodic auto-refresh.
module tb_indicator_driver;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_a, rst_b, rst_c;
  logic start_a, start_b, start_c;
  logic lamp, lamp_c;
  logic [15:0] dv;
  logic [7:0]  dc;

  logic busy_a, done_a, sclk_a, sdata_a, slatch_a;
  logic busy_b, done_b, sclk_b, sdata_b, slatch_b;
  logic busy_c, done_c, sclk_c, sdata_c, slatch_c;

  indicator_driver #(.ROWS(1), .COLS(8), .DIV(1), .REFRESH(0), .LAYOUT(0)) dut_a (
    .clk(clk), .reset(rst_a), .d(dv[7:0]), .start(start_a), .lamp_test(lamp),
    .busy(busy_a), .done(done_a), .sclk(sclk_a), .sdata(sdata_a), .slatch(slatch_a));

  indicator_driver #(.ROWS(4), .COLS(4), .DIV(2), .REFRESH(0), .LAYOUT(1)) dut_b (
    .clk(clk), .reset(rst_b), .d(dv), .start(start_b), .lamp_test(lamp),
    .busy(busy_b), .done(done_b), .sclk(sclk_b), .sdata(sdata_b), .slatch(slatch_b));

  indicator_driver #(.ROWS(1), .COLS(8), .DIV(1), .REFRESH(100), .LAYOUT(0)) dut_c (
    .clk(clk), .reset(rst_c), .d(dc), .start(start_c), .lamp_test(lamp_c),
    .busy(busy_c), .done(done_c), .sclk(sclk_c), .sdata(sdata_c), .slatch(slatch_c));

  int sel;
  logic o_busy, o_done, o_sclk, o_sdata, o_slatch;

  always_comb begin
    case (sel)
      0: {o_busy, o_done, o_sclk, o_sdata, o_slatch} = {busy_a, done_a, sclk_a, sdata_a, slatch_a};
      1: {o_busy, o_done, o_sclk, o_sdata, o_slatch} = {busy_b, done_b, sclk_b, sdata_b, slatch_b};
      default: {o_busy, o_done, o_sclk, o_sdata, o_slatch} = {busy_c, done_c, sclk_c, sdata_c, slatch_c};
    endcase
  end

  int total, bad;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // capture results (t = cycles after the trigger edge, sampled at negedge)
  logic [15:0] cap_bits;
  int cap_n, cap_rise, cap_latch, cap_latch_len, cap_done, cap_done_len;
  logic cap_busy0, cap_sdata0, cap_busy_dn, cap_busy_after;

  task automatic capture(input int maxcyc, input bit aligned, input int tog_t,
                         input int pulse_t, input int npulse);
    logic prev, p;
    cap_bits = 16'h0; cap_n = 0; cap_rise = -1; cap_latch = -1; cap_latch_len = 0;
    cap_done = -1; cap_done_len = 0; cap_busy0 = 1'b0; cap_sdata0 = 1'b0;
    cap_busy_dn = 1'b1; cap_busy_after = 1'b1; prev = 1'b0;
    for (int t = 0; t < maxcyc; t++) begin
      if (!(aligned && t == 0)) @(negedge clk);
      p = (npulse > 0) && (t >= pulse_t) && (t < pulse_t + 2*npulse) && (((t - pulse_t) % 2) == 0);
      start_a = (sel == 0) ? p : 1'b0;
      start_b = (sel == 1) ? p : 1'b0;
      if (t == tog_t) begin
        dv   = dv ^ 16'h5A5A;
        lamp = 1'b0;
      end
      if (t == 0) begin
        cap_busy0  = o_busy;
        cap_sdata0 = o_sdata;
      end
      if (o_sclk && !prev) begin
        cap_bits = {cap_bits[14:0], o_sdata};
        cap_n++;
        if (cap_rise < 0) cap_rise = t;
      end
      prev = o_sclk;
      if (o_slatch) begin
        if (cap_latch < 0) cap_latch = t;
        cap_latch_len++;
      end
      if (cap_done >= 0) begin
        cap_busy_after = o_busy;
        if (o_done) cap_done_len++;
        break;
      end
      if (o_done) begin
        cap_done     = t;
        cap_done_len = 1;
        cap_busy_dn  = o_busy;
      end
    end
  endtask

  task automatic check_xfer(input string tag, input logic [15:0] exp, input int div, input int n,
                            input logic exp_busy_after);
    chk({tag, "_bits"},     32'(cap_bits), 32'(exp));
    chk({tag, "_nbits"},    cap_n, n);
    chk({tag, "_sdata0"},   32'(cap_sdata0), 32'(exp[n-1]));
    chk({tag, "_busy0"},    32'(cap_busy0), 32'd1);
    chk({tag, "_rise"},     cap_rise, div);
    chk({tag, "_latch_t"},  cap_latch, 2*div*n);
    chk({tag, "_latch_w"},  cap_latch_len, div);
    chk({tag, "_done_t"},   cap_done, 2*div*n + div);
    chk({tag, "_done_w"},   cap_done_len, 1);
    chk({tag, "_busy_dn"},  32'(cap_busy_dn), 32'd0);
    chk({tag, "_busy_aft"}, 32'(cap_busy_after), 32'(exp_busy_after));
  endtask

  task automatic xfer(input string tag, input int s, input logic [15:0] dval,
                      input logic [15:0] exp, input int div, input int n,
                      input logic lt, input int tog_t);
    @(negedge clk);
    sel = s; dv = dval; lamp = lt;
    if (s == 0) start_a = 1'b1; else start_b = 1'b1;
    capture(2*div*n + div + 10, 1'b0, tog_t, 0, 0);
    check_xfer(tag, exp, div, n, 1'b0);
    lamp = 1'b0;
  endtask

  int t1, t2, t3, seen;

  initial begin
    total = 0; bad = 0; sel = 0;
    rst_a = 1'b1; rst_b = 1'b1; rst_c = 1'b1;
    start_a = 1'b0; start_b = 1'b0; start_c = 1'b0;
    lamp = 1'b0; lamp_c = 1'b0; dv = 16'h0; dc = 8'h81;
    repeat (3) @(posedge clk);
    @(negedge clk);
    sel = 0; #1;
    chk("reset_a", 32'({o_busy, o_done, o_sclk, o_sdata, o_slatch}), 32'd0);
    sel = 1; #1;
    chk("reset_b", 32'({o_busy, o_done, o_sclk, o_sdata, o_slatch}), 32'd0);
    rst_a = 1'b0; rst_b = 1'b0; rst_c = 1'b0;
    repeat (2) @(negedge clk);

    // linear 1x8, d=A5: bits 1,0,1,0,0,1,0,1 at rises 1..15, latch 16, done 17
    xfer("lin_a5", 0, 16'h00A5, 16'h00A5, 1, 8, 1'b0, -1);
    xfer("lin_3c", 0, 16'h003C, 16'h003C, 1, 8, 1'b0, -1);
    // d changes mid-transfer (A5 -> FF) must not disturb the stream
    xfer("lin_iso", 0, 16'h00A5, 16'h00A5, 1, 8, 1'b0, 4);

    // panel 4x4: r0c0 -> 15th bit, r3c3 -> 7th bit, r2c0 -> 1st, r1c0 -> 16th
    xfer("pan_r0c0", 1, 16'h0001, 16'h0002, 2, 16, 1'b0, -1);
    xfer("pan_r3c3", 1, 16'h8000, 16'h0200, 2, 16, 1'b0, -1);
    xfer("pan_r2r1", 1, 16'h0110, 16'h8001, 2, 16, 1'b0, -1);
    // lamp test with d=0, then d and lamp_test change mid-transfer
    xfer("pan_lamp", 1, 16'h0000, 16'hFFFF, 2, 16, 1'b1, 10);

    // three starts during one transfer: exactly one follow-up, busy low one cycle
    @(negedge clk);
    sel = 0; dv = 16'h00A5; start_a = 1'b1;
    capture(40, 1'b0, -1, 3, 3);
    check_xfer("b2b_first", 16'h00A5, 1, 8, 1'b1);
    capture(40, 1'b1, -1, 0, 0);
    check_xfer("b2b_second", 16'h00A5, 1, 8, 1'b0);
    seen = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (o_busy) seen++;
    end
    chk("b2b_no_third", seen, 0);

    // reset while sclk is high aborts without latch or done
    @(negedge clk);
    sel = 0; dv = 16'h00A5; start_a = 1'b1;
    @(negedge clk); start_a = 1'b0;
    @(negedge clk);
    chk("rst_in_shift_hi", 32'({o_busy, o_sclk, o_sdata}), 32'b111);
    #2 rst_a = 1'b1;
    #1;
    chk("rst_async_outs", 32'({o_busy, o_done, o_sclk, o_sdata, o_slatch}), 32'd0);
    seen = 0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      if (o_slatch || o_done || o_busy) seen++;
    end
    rst_a = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      if (o_slatch || o_done || o_busy) seen++;
    end
    chk("rst_no_latch_done", seen, 0);
    xfer("post_rst", 0, 16'h0096, 16'h0096, 1, 8, 1'b0, -1);

    // auto-refresh: done pulses 2*1*8+1+100 = 117 cycles apart
    sel = 2; #1;
    t1 = -1; t2 = -1; t3 = -1;
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      if (o_done) begin
        if (t1 < 0) t1 = i;
        else if (t2 < 0) t2 = i;
        else begin
          t3 = i;
          break;
        end
      end
    end
    chk("refresh_seen", 32'(t3 >= 0), 32'd1);
    chk("refresh_gap1", t2 - t1, 117);
    chk("refresh_gap2", t3 - t2, 117);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/indicator_driver.md
# indicator_driver

Parametrised successor to the front-panel indicator shifter. It snapshots a ROWS×COLS lamp array and optionally reorders it into the panel PCB bit order. It generates its own serial clock, data and latch strobe for the LED driver chain from the single system clock. It sits between the QSIC status logic and the panel connector, and supports software-requested refresh, periodic auto-refresh and a lamp-test mode.

## Interface
Parameters:
- ROWS, 4, number of display lines.
- COLS, 36, lamps per line.
- DIV, 50, system clocks per serial half-period, ≥1. Also the latch pulse width.
- REFRESH, 0, idle cycles between automatic refreshes. 0 disables auto-refresh.
- LAYOUT, 1, bit ordering. 0 = linear. 1 = panel order, which requires ROWS=4 and COLS%4==0 (elaboration error otherwise).

Ports:
- clk  in  1  system clock; everything is on posedge.
- reset  in  1  asynchronous, active-high.
- d  in  ROWS*COLS  lamp state. Row r, column c is d[r*COLS+c].
- start  in  1  request a refresh (level sampled each clock).
- lamp_test  in  1  when 1 at snapshot, all lamps are sent as 1.
- busy  out  1  transfer in progress.
- done  out  1  one-cycle pulse after latch completes.
- sclk  out  1  serial clock to the LED driver. The driver samples on its rising edge.
- sdata  out  1  serial data, MSB of the shift register.
- slatch  out  1  latch strobe to the LED driver.

## Operation
- N = ROWS*COLS bits per transfer. FSM states are IDLE, SHIFT_LO, SHIFT_HI and LATCH.
- IDLE
  - A trigger is start, pending, or the refresh counter reaching REFRESH-1 when REFRESH≠0.
  - On a trigger: snapshot the mapped d (or all ones if lamp_test) into the N-bit shift register, clear pending and the refresh counter, go to SHIFT_LO.
  - With no trigger, the refresh counter increments.
- SHIFT_LO: sclk=0. After DIV cycles, go to SHIFT_HI.
- SHIFT_HI: sclk=1. After DIV cycles:
  - shift left by one and increment the bit counter;
  - go to LATCH if N bits have been sent, else SHIFT_LO.
- LATCH: sclk=0, slatch=1 for DIV cycles, then IDLE with done=1 for that single cycle.
- start while busy sets a one-deep pending flag. Further starts while pending are absorbed. Pending is serviced on the done cycle.
- LAYOUT=0: d[N-1] is sent first, d[0] last.
- LAYOUT=1 sends groups g=0..COLS/4-1 in order, 16 bits each. With ci=4g+i, rK = row K, the sequence is:
  - r2c0, r3c0, r2c1, r3c1,
  - r3c2, r2c2, r3c3, r2c3,
  - r1c3, r0c3, r1c2, r0c2,
  - r0c1, r1c1, r0c0, r1c0.
- Snapshot isolation: changes to d or lamp_test after the snapshot edge do not affect the transfer in progress.

## Timing
- Reset values:
  - outputs: busy=0, done=0, sclk=0, sdata=0, slatch=0;
  - internal: state IDLE, pending=0, counters=0, shift register=0.
- Trigger at edge k:
  - busy=1 and sdata = first bit from k+1;
  - sclk rises at k+DIV(2j+1) and falls at k+2DIV(j+1) for bit j;
  - sdata changes only on sclk falling edges, so it is stable for DIV cycles either side of each rise.
- slatch is high from edge k+2·DIV·N to k+2·DIV·N+DIV. sclk is low throughout.
- done is high, busy low, for exactly one cycle starting at k+2·DIV·N+DIV.
- Total cycles from trigger to done = 2·DIV·N+DIV.
- Back-to-back: with pending set, the next trigger is the done edge, so busy is low for exactly one cycle.
- Auto-refresh: with no start, successive transfers are separated by exactly REFRESH idle cycles (done cycle included).
- Reset mid-transfer aborts immediately. No latch pulse and no done are produced.
- start and the refresh match in the same IDLE cycle give a single transfer.

## Structure
- Package indicator_pkg holds:
  - the state enum;
  - LAYOUT_LINEAR / LAYOUT_PANEL constants;
  - a function giving the serial position of (row, col) for each layout.
- Sub-module indicator_map is combinational. It is parametrised by ROWS, COLS and LAYOUT and permutes d into shift-register order.
- Counter widths are sized with clog2: div counter to DIV, bit counter to N+1, refresh counter to REFRESH.

## Test plan
- ROWS=1, COLS=8, DIV=1, LAYOUT=0, d=8'hA5, start pulse at edge 0:
  - sdata sampled at sclk rises (edges 1,3,…,15) = 1,0,1,0,0,1,0,1;
  - slatch high for edges 16–17, done at edge 17.
- ROWS=4, COLS=4, LAYOUT=1, DIV=2, only r0c0 set: exactly the 15th transmitted bit is 1. Repeat for r3c3: only the 7th bit is 1.
- lamp_test=1 with d=0: all N bits are 1. Toggling d mid-transfer does not change the sampled stream.
- start asserted during a transfer: the second transfer starts on the done edge and busy is low for exactly one cycle. Three starts during one transfer yield only one extra transfer.
- REFRESH=100 with no start: done pulses are 2·DIV·N+DIV+100 cycles apart.
- Reset asserted during SHIFT_HI: all outputs are 0 asynchronously, with no slatch or done. A fresh start afterwards produces a correct full transfer.
